// File: rtl/pgr_uart_tx_stream.sv
// -----------------------------------------------------------------------------
// pgr_uart_tx_stream
//
// UART transmitter fed by a valid/ready byte stream. Bytes taken from upstream
// land in a one-entry holding register; the frame engine pulls from it at the
// start of each frame and again at the final stop boundary. Back-to-back
// frames therefore leave no idle gap on the line.
//
// Frame on txd: start(0), data[0..7] LSB first, optional parity, 1 or 2 stop(1).
//
// Parameters:
//   CLK_DIV   - clk cycles per bit period (2..65535)
//   PARITY    - "NONE", "EVEN" or "ODD"
//   STOP_BITS - 1 or 2
//
// Ports:
//   clk           - system clock, rising edge
//   rst           - asynchronous active-high reset
//   data_in_valid - upstream byte valid
//   data_in       - upstream byte
//   data_in_ready - holding register empty; byte taken on valid & ready
//   txd           - registered serial output, idles high
//   tx_busy       - registered; frame in progress or byte held
// -----------------------------------------------------------------------------
module pgr_uart_tx_stream #(
  parameter int unsigned CLK_DIV   = 868,
  parameter string       PARITY    = "NONE",
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_in_valid,
  input  logic [7:0] data_in,
  output logic       data_in_ready,
  output logic       txd,
  output logic       tx_busy
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (CLK_DIV < 2 || CLK_DIV > 65535) begin : g_bad_clk_div
    $error("pgr_uart_tx_stream: CLK_DIV must be in 2..65535");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("pgr_uart_tx_stream: STOP_BITS must be 1 or 2");
  end
  if (PARITY != "NONE" && PARITY != "EVEN" && PARITY != "ODD") begin : g_bad_parity
    $error("pgr_uart_tx_stream: PARITY must be NONE, EVEN or ODD");
  end

  localparam logic [15:0] BaudLast = 16'(CLK_DIV - 1);
  localparam bit          ParEn    = (PARITY != "NONE");
  localparam bit          ParOdd   = (PARITY == "ODD");
  // Value of stop_q on the last stop bit.
  localparam logic        StopLast = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic        stop_q, stop_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_vld_q, hold_vld_d;
  logic        txd_q, txd_d;
  logic        busy_q, busy_d;

  logic        baud_done;
  logic        accept;
  logic        load;

  assign baud_done     = (baud_q == BaudLast);
  // Ready depends only on the holding register, so accept and load never
  // coincide: load needs hold_vld_q=1, accept needs it 0.
  assign data_in_ready = ~hold_vld_q;
  assign accept        = data_in_valid & ~hold_vld_q;

  assign txd     = txd_q;
  assign tx_busy = busy_q;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and frame counters
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    par_d   = par_q;
    load    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (hold_vld_q) begin
          load = 1'b1;
        end
      end

      StStart: begin
        if (baud_done) begin
          state_d = StData;
          bit_d   = 3'd0;
          baud_d  = 16'd0;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end

      StData: begin
        if (baud_done) begin
          baud_d  = 16'd0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = ParEn ? StParity : StStop;
            stop_d  = 1'b0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end

      StParity: begin
        if (baud_done) begin
          state_d = StStop;
          stop_d  = 1'b0;
          baud_d  = 16'd0;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end

      StStop: begin
        if (baud_done) begin
          baud_d = 16'd0;
          if (stop_q == StopLast) begin
            // Final stop boundary: chain straight into the next frame if a
            // byte is waiting, otherwise go quiet.
            if (hold_vld_q) begin
              load = 1'b1;
            end else begin
              state_d = StIdle;
            end
          end else begin
            stop_d = 1'b1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end

      default: begin
        state_d = StIdle;
        baud_d  = 16'd0;
      end
    endcase

    if (load) begin
      state_d = StStart;
      baud_d  = 16'd0;
      shift_d = hold_q;
      par_d   = ParOdd ? ~^hold_q : ^hold_q;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    txd_d = 1'b1;
    unique case (state_q)
      StIdle:   txd_d = 1'b1;
      StStart:  txd_d = 1'b0;
      StData:   txd_d = shift_q[0];
      StParity: txd_d = par_q;
      StStop:   txd_d = 1'b1;
      default:  txd_d = 1'b1;
    endcase
    busy_d = (state_d != StIdle) | hold_vld_d;
  end

  // ---------------------------------------------------------------------------
  // Holding register
  // ---------------------------------------------------------------------------
  always_comb begin
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    if (load) begin
      hold_vld_d = 1'b0;
    end else if (accept) begin
      hold_vld_d = 1'b1;
      hold_d     = data_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_q     <= 16'd0;
      bit_q      <= 3'd0;
      stop_q     <= 1'b0;
      shift_q    <= 8'd0;
      par_q      <= 1'b0;
      hold_q     <= 8'd0;
      hold_vld_q <= 1'b0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      stop_q     <= stop_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: tb/tb_pgr_uart_tx_stream.sv
// -----------------------------------------------------------------------------
// tb_pgr_uart_tx_stream
//
// Four DUT instances (CLK_DIV=4): NONE/1 stop, EVEN/1, ODD/1, NONE/2 stop.
// A timeline model predicts txd, data_in_ready and tx_busy each cycle from
// handshake times: each accepted byte becomes a frame whose first line cycle
// is max(handshake+2, end of previous frame).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pgr_uart_tx_stream;

  localparam int DIV = 4;
  localparam int NI  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid [NI];
  logic [7:0] din   [NI];
  logic       ready [NI];
  logic       txd   [NI];
  logic       busy  [NI];

  int nvec  = 0;
  int nfail = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pgr_uart_tx_stream #(.CLK_DIV(DIV), .PARITY("NONE"), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst(rst), .data_in_valid(valid[0]), .data_in(din[0]),
    .data_in_ready(ready[0]), .txd(txd[0]), .tx_busy(busy[0])
  );
  pgr_uart_tx_stream #(.CLK_DIV(DIV), .PARITY("EVEN"), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .rst(rst), .data_in_valid(valid[1]), .data_in(din[1]),
    .data_in_ready(ready[1]), .txd(txd[1]), .tx_busy(busy[1])
  );
  pgr_uart_tx_stream #(.CLK_DIV(DIV), .PARITY("ODD"), .STOP_BITS(1)) u_dut2 (
    .clk(clk), .rst(rst), .data_in_valid(valid[2]), .data_in(din[2]),
    .data_in_ready(ready[2]), .txd(txd[2]), .tx_busy(busy[2])
  );
  pgr_uart_tx_stream #(.CLK_DIV(DIV), .PARITY("NONE"), .STOP_BITS(2)) u_dut3 (
    .clk(clk), .rst(rst), .data_in_valid(valid[3]), .data_in(din[3]),
    .data_in_ready(ready[3]), .txd(txd[3]), .tx_busy(busy[3])
  );

  // ---------------------------------------------------------------------------
  // Comparison helpers
  // ---------------------------------------------------------------------------
  function automatic void chk_bit(string name, int inst, logic act, logic exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s inst%0d cyc=%0d: got %b, want %b", name, inst, cyc, act, exp);
    end
  endfunction

  function automatic void chk_int(string name, int inst, int act, int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s inst%0d cyc=%0d: got %0d, want %0d", name, inst, cyc, act, exp);
    end
  endfunction

  function automatic void timeout(string name, int inst);
    nvec++;
    nfail++;
    $display("FAIL %s inst%0d cyc=%0d: got timeout, want event", name, inst, cyc);
  endfunction

  function automatic logic bit_at(logic [11:0] l, int k);
    logic [11:0] t;
    t = l >> k;
    return t[0];
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic int par_mode(int i);  // 0 none, 1 even, 2 odd
    return (i == 1) ? 1 : (i == 2) ? 2 : 0;
  endfunction

  function automatic int nbits_of(int i);
    return 1 + 8 + ((par_mode(i) != 0) ? 1 : 0) + ((i == 3) ? 2 : 1);
  endfunction

  // Bit k of the result is the line level during bit period k; unused
  // upper positions are idle-high, which also covers the stop bits.
  function automatic logic [11:0] line_of(int i, logic [7:0] d);
    logic p;
    p = 1'b1;
    if (par_mode(i) == 1) p = ^d;
    if (par_mode(i) == 2) p = ~^d;
    if (par_mode(i) == 0) return {3'b111, d, 1'b0};
    return {2'b11, p, d, 1'b0};
  endfunction

  typedef struct {
    int          hs;
    int          start;
    int          len;
    logic [11:0] line;
  } frame_t;

  frame_t fr [NI][256];
  int     fcnt     [NI];
  int     fbase    [NI];
  int     last_end [NI];
  logic   et, er, eb;

  function automatic void add_frame(int i, logic [7:0] d);
    frame_t f;
    f.hs    = cyc + 1;
    f.len   = nbits_of(i) * DIV;
    f.line  = line_of(i, d);
    f.start = (f.hs + 2 > last_end[i]) ? f.hs + 2 : last_end[i];
    last_end[i] = f.start + f.len;
    if (fcnt[i] < 256) begin
      fr[i][fcnt[i]] = f;
      fcnt[i]++;
    end else begin
      timeout("model_capacity", i);
    end
  endfunction

  // Inputs only change just after posedge, so the negedge view equals what
  // the DUT samples on the next edge.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        fbase[i]    = fcnt[i];
        last_end[i] = 0;
        chk_bit("rst_txd", i, txd[i], 1'b1);
        chk_bit("rst_ready", i, ready[i], 1'b1);
        chk_bit("rst_busy", i, busy[i], 1'b0);
      end else begin
        while (fbase[i] < fcnt[i] && cyc >= fr[i][fbase[i]].start + fr[i][fbase[i]].len)
          fbase[i]++;
        et = 1'b1;
        er = 1'b1;
        eb = 1'b0;
        for (int k = fbase[i]; k < fcnt[i]; k++) begin
          if (cyc >= fr[i][k].start && cyc < fr[i][k].start + fr[i][k].len)
            et = bit_at(fr[i][k].line, (cyc - fr[i][k].start) / DIV);
          if (cyc >= fr[i][k].hs && cyc < fr[i][k].start - 1) er = 1'b0;
          if (cyc >= fr[i][k].hs && cyc < fr[i][k].start + fr[i][k].len - 1) eb = 1'b1;
        end
        chk_bit("txd", i, txd[i], et);
        chk_bit("ready", i, ready[i], er);
        chk_bit("busy", i, busy[i], eb);
        if (valid[i] && er) add_frame(i, din[i]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus tasks
  // ---------------------------------------------------------------------------
  logic [7:0] sbytes [$];

  task automatic send(input int i, input logic [7:0] d, output int hs);
    int g;
    g  = 0;
    hs = -1;
    @(posedge clk); #1;
    valid[i] = 1'b1;
    din[i]   = d;
    while (hs < 0 && g < 200) begin
      @(negedge clk);
      if (ready[i]) hs = cyc + 1;
      @(posedge clk); #1;
      g++;
    end
    valid[i] = 1'b0;
    if (hs < 0) timeout("send", i);
  endtask

  task automatic stream_send(input int i, input int n);
    int   k;
    int   g;
    logic hsn;
    k = 0;
    g = 0;
    @(posedge clk); #1;
    valid[i] = 1'b1;
    din[i]   = sbytes[0];
    while (k < n && g < 1000) begin
      @(negedge clk);
      hsn = ready[i];
      @(posedge clk); #1;
      g++;
      if (hsn) begin
        k++;
        if (k < n) din[i] = sbytes[k];
        else valid[i] = 1'b0;
      end
    end
    if (k < n) begin
      valid[i] = 1'b0;
      timeout("stream", i);
    end
  endtask

  task automatic at_cyc(input int c);
    for (int g = 0; g < 2000; g++) begin
      @(negedge clk);
      if (cyc >= c) break;
    end
    if (cyc != c) timeout("schedule", 0);
  endtask

  task automatic wait_start(input int i, input int from, output int st);
    st = -1;
    for (int g = 0; g < 400 && st < 0; g++) begin
      @(negedge clk);
      if (cyc >= from && txd[i] == 1'b0) st = cyc;
    end
    if (st < 0) timeout("start", i);
  endtask

  task automatic wait_idle(input int i, output int e);
    e = -1;
    for (int g = 0; g < 400 && e < 0; g++) begin
      @(negedge clk);
      if (busy[i] == 1'b0) e = cyc;
    end
    if (e < 0) timeout("idle", i);
  endtask

  task automatic rx_byte(input int i, input int from, output logic [7:0] b, output int st);
    b = 8'h00;
    wait_start(i, from, st);
    if (st >= 0) begin
      for (int k = 0; k < 8; k++) begin
        at_cyc(st + (k + 1) * DIV + DIV / 2);
        b[k] = txd[i];
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    int          inst;
    logic [7:0]  data;
    logic [11:0] line;
    int          nbits;
  } vec_t;

  vec_t tbl [5];
  logic hsn_r [NI];

  initial begin
    int          hs, st, st2, e;
    logic [7:0]  b, b2;

    for (int i = 0; i < NI; i++) begin
      valid[i] = 1'b0;
      din[i]   = 8'h00;
    end

    tbl[0] = '{0, 8'hA5, {2'b11, 1'b1, 8'hA5, 1'b0}, 10};
    tbl[1] = '{1, 8'h07, {2'b11, 1'b1, 8'h07, 1'b0}, 11};  // even parity -> 1
    tbl[2] = '{2, 8'h07, {2'b11, 1'b0, 8'h07, 1'b0}, 11};  // odd parity -> 0
    tbl[3] = '{3, 8'hFF, {2'b11, 1'b1, 8'hFF, 1'b0}, 11};  // two stop bits
    tbl[4] = '{0, 8'h00, {2'b11, 1'b1, 8'h00, 1'b0}, 10};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);

    for (int v = 0; v < 5; v++) begin
      send(tbl[v].inst, tbl[v].data, hs);
      wait_start(tbl[v].inst, hs, st);
      chk_int("start_latency", tbl[v].inst, st - hs, 2);
      for (int k = 0; k < tbl[v].nbits; k++) begin
        at_cyc(st + k * DIV + DIV / 2);
        chk_bit("line_bit", tbl[v].inst, txd[tbl[v].inst], bit_at(tbl[v].line, k));
      end
      wait_idle(tbl[v].inst, e);
      chk_int("frame_cycles", tbl[v].inst, e - st + 1, tbl[v].nbits * DIV);
    end

    // Back-to-back with valid held: zero gap, 80 cycles for two frames.
    sbytes = '{8'h55, 8'h0F};
    fork
      stream_send(0, 2);
      begin
        rx_byte(0, cyc, b, st);
        rx_byte(0, st + 9 * DIV, b2, st2);
      end
    join
    chk_int("b2b_byte0", 0, int'(b), 32'h55);
    chk_int("b2b_byte1", 0, int'(b2), 32'h0F);
    chk_int("b2b_gap", 0, st2 - st, 10 * DIV);
    wait_idle(0, e);
    chk_int("b2b_total", 0, e - st + 1, 20 * DIV);

    // Two stop bits, held next byte follows immediately.
    sbytes = '{8'hFF, 8'h81};
    fork
      stream_send(3, 2);
      begin
        rx_byte(3, cyc, b, st);
        rx_byte(3, st + 9 * DIV, b2, st2);
      end
    join
    chk_int("stop2_byte1", 3, int'(b2), 32'h81);
    chk_int("stop2_gap", 3, st2 - st, 11 * DIV);

    // Backpressure: three bytes, valid held throughout.
    sbytes = '{8'h01, 8'h02, 8'h03};
    fork
      stream_send(0, 3);
      begin
        st = cyc;
        for (int n = 0; n < 3; n++) begin
          rx_byte(0, (n == 0) ? st : st + 9 * DIV, b, st);
          chk_int("bp_byte", 0, int'(b), n + 1);
        end
      end
    join
    repeat (60) @(posedge clk);

    // Reset mid-frame during data bit 3 of 0xC3 with a second byte held.
    send(0, 8'hC3, hs);
    send(0, 8'h3C, e);
    wait_start(0, hs, st);
    at_cyc(st + 4 * DIV + 1);
    chk_bit("pre_rst_txd", 0, txd[0], 1'b0);
    chk_bit("pre_rst_busy", 0, busy[0], 1'b1);
    chk_bit("pre_rst_ready", 0, ready[0], 1'b0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk_bit("async_rst_txd", 0, txd[0], 1'b1);
    chk_bit("async_rst_busy", 0, busy[0], 1'b0);
    chk_bit("async_rst_ready", 0, ready[0], 1'b1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk_bit("post_rst_idle", 0, txd[0], 1'b1);
    end
    send(0, 8'h5A, hs);
    rx_byte(0, hs, b, st);
    chk_int("post_rst_byte", 0, int'(b), 32'h5A);
    chk_int("post_rst_latency", 0, st - hs, 2);
    repeat (50) @(posedge clk);

    // Randomized traffic on all instances, checked by the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) hsn_r[i] = valid[i] && ready[i];
      @(posedge clk); #1;
      for (int i = 0; i < NI; i++) begin
        if (hsn_r[i]) begin
          valid[i] = ($urandom_range(0, 1) == 0);
          din[i]   = 8'($urandom);
        end else if (!valid[i]) begin
          valid[i] = ($urandom_range(0, 3) == 0);
          din[i]   = 8'($urandom);
        end
      end
    end
    for (int i = 0; i < NI; i++) valid[i] = 1'b0;
    for (int i = 0; i < NI; i++) wait_idle(i, e);
    repeat (20) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d: got no finish, want finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
